// File: rtl/up_dn_cntr_pkg.sv
// up_dn_cntr_pkg: shared constants and helpers for the modulo up/down counter.
//   DIR_UP / DIR_DN   : encodings of the dir input
//   N_DEF / STEP_W_DEF: default counter and step widths
//   clamp_step()      : min(step, max_val+1), returned one bit wider than the
//                       operands so max_val+1 never overflows
// clamp_step works on CLAMP_W-bit operands; callers zero-extend in and
// truncate out, so any counter width up to CLAMP_W is supported.
package up_dn_cntr_pkg;
  localparam logic DIR_UP     = 1'b1;
  localparam logic DIR_DN     = 1'b0;
  localparam int   N_DEF      = 8;
  localparam int   STEP_W_DEF = 4;
  localparam int   CLAMP_W    = 32;

  function automatic logic [CLAMP_W:0] clamp_step(input logic [CLAMP_W-1:0] step,
                                                  input logic [CLAMP_W-1:0] max_val);
    logic [CLAMP_W:0] mp1;
    logic [CLAMP_W:0] stp;
    mp1 = {1'b0, max_val} + (CLAMP_W+1)'(1);
    stp = {1'b0, step};
    return (stp > mp1) ? mp1 : stp;
  endfunction
endpackage

// File: rtl/mod_up_dn_cntr_cntr_next.sv
// cntr_next: combinational next-state for the modulo up/down counter.
//   i_out       : current count
//   i_dir       : DIR_UP / DIR_DN
//   i_step      : raw step (clamped to max_val+1 here)
//   i_max_val   : terminal value, range is [0, i_max_val]
//   i_sat       : 1 = saturate at the ends instead of wrapping
//   o_next_out  : count after one enabled edge
//   o_next_wrap : 1 when that edge wraps (or recovers from out > max_val)
module cntr_next
  import up_dn_cntr_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic [N-1:0]      i_out,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_step,
  input  logic [N-1:0]      i_max_val,
  input  logic              i_sat,
  output logic [N-1:0]      o_next_out,
  output logic              o_next_wrap
);
  // All arithmetic in N+1 bits: out + step and out + max_val + 1 both fit.
  logic [N:0]   w_cur, w_max, w_mp1, w_stp, w_sum;
  logic [N-1:0] w_up_wr, w_dn_sub, w_dn_wr;
  logic         w_oor;

  assign w_cur    = {1'b0, i_out};
  assign w_max    = {1'b0, i_max_val};
  assign w_mp1    = w_max + (N+1)'(1);
  assign w_stp    = (N+1)'(clamp_step(CLAMP_W'(i_step), CLAMP_W'(i_max_val)));
  assign w_sum    = w_cur + w_stp;
  assign w_up_wr  = N'(w_sum - w_mp1);
  assign w_dn_sub = N'(w_cur - w_stp);
  assign w_dn_wr  = N'(w_cur + w_mp1 - w_stp);
  // max_val may drop below the current count at runtime.
  assign w_oor    = i_out > i_max_val;

  always_comb begin
    o_next_out  = i_out;
    o_next_wrap = 1'b0;
    if (w_oor) begin
      // Snap back into range from the side we are heading towards.
      o_next_out  = (i_dir == DIR_UP) ? '0 : i_max_val;
      o_next_wrap = 1'b1;
    end else if (i_dir == DIR_UP) begin
      if (w_sum <= w_max) begin
        o_next_out = N'(w_sum);
      end else if (i_sat) begin
        o_next_out = i_max_val;
      end else begin
        o_next_out  = w_up_wr;
        o_next_wrap = 1'b1;
      end
    end else begin
      if (w_cur >= w_stp) begin
        o_next_out = w_dn_sub;
      end else if (i_sat) begin
        o_next_out = '0;
      end else begin
        o_next_out  = w_dn_wr;
        o_next_wrap = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mod_up_dn_cntr.sv
// mod_up_dn_cntr: modulo up/down counter over [0, max_val] with enable,
// synchronous load (clipped to max_val), programmable step and a one-cycle
// wrap pulse.
//   clk, rst_n : clock, async active-low reset
//   en, dir    : count enable, direction (1 = up)
//   load       : synchronous load of min(load_val, max_val), beats en
//   max_val    : terminal value
//   step       : count amount, 0 = hold
//   sat        : saturate instead of wrap (only with UP_DN_CNTR_SAT_EN)
//   out, wrap  : registered count and wrap pulse
//   at_max     : combinational out == max_val
//   at_min     : combinational out == 0
// Build option: define UP_DN_CNTR_SAT_EN to add the sat port.
module mod_up_dn_cntr
  import up_dn_cntr_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic [N-1:0]      max_val,
  input  logic [STEP_W-1:0] step,
`ifdef UP_DN_CNTR_SAT_EN
  input  logic              sat,
`endif
  output logic [N-1:0]      out,
  output logic              wrap,
  output logic              at_max,
  output logic              at_min
);
  logic [N-1:0] r_out;
  logic         r_wrap;
  logic [N-1:0] w_next_out, w_load_clip;
  logic         w_next_wrap, w_sat;

`ifdef UP_DN_CNTR_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  assign w_load_clip = (load_val > max_val) ? max_val : load_val;

  cntr_next #(.N(N), .STEP_W(STEP_W)) u_next (
    .i_out      (r_out),
    .i_dir      (dir),
    .i_step     (step),
    .i_max_val  (max_val),
    .i_sat      (w_sat),
    .o_next_out (w_next_out),
    .o_next_wrap(w_next_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_out  <= w_load_clip;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_out  <= w_next_out;
      r_wrap <= w_next_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign out    = r_out;
  assign wrap   = r_wrap;
  assign at_max = (r_out == max_val);
  assign at_min = (r_out == '0);
endmodule
